student_dmux4way16_router: RTL and testbench

- Sequential inverse of the 4-way 16-bit multiplexer: one 16-bit input stream is steered by `sel` to one of four output channels `a`/`b`/`c`/`d`.
- Each channel has its own small FIFO and a valid/ready handshake, so a stalled consumer on one channel does not block traffic to the others.
- Sits in the project-1 datapath library as the fan-out counterpart to the mux, with a matching directed test bench.

---
 rtl/student_dmux4way16_router.sv | 165 ++++++++++++++++
 tb/tb_student_dmux4way16_router.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/student_dmux4way16_router.sv
// student_dmux4way16_router
//
// Purpose:
//   Fan-out counterpart of the 4-way 16-bit multiplexer. A single 16-bit
//   input stream is steered by `sel` into one of four channels (a/b/c/d).
//   Each channel owns a small FIFO with a valid/ready handshake, so a stalled
//   consumer on one channel never blocks traffic headed for the others.
//
// Parameters:
//   DEPTH - entries per channel FIFO (power of two, 2..16)
//   AW    - pointer width, log2(DEPTH)
//
// Ports:
//   clk, rst_n          - rising-edge clock, asynchronous active-low reset
//   in, sel, in_valid   - producer word, destination channel, word present
//   in_ready            - selected channel is not full (combinational)
//   a..d                - head-of-FIFO data per channel
//   a_valid..d_valid    - channel FIFO non-empty
//   a_ready..d_ready    - consumer takes the head word this cycle
//   a_count..d_count    - channel occupancy, 0..DEPTH
//
// Build option:
//   DMUX_ZERO_IDLE_EN - when defined, a/b/c/d read as 16'h0000 while their
//   channel is empty; otherwise they show the storage slot at the read
//   pointer (stale data, or zero straight after reset).

module student_dmux4way16_router #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   in,
  input  logic [1:0]    sel,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [15:0]   a,
  output logic [15:0]   b,
  output logic [15:0]   c,
  output logic [15:0]   d,
  output logic          a_valid,
  output logic          b_valid,
  output logic          c_valid,
  output logic          d_valid,
  input  logic          a_ready,
  input  logic          b_ready,
  input  logic          c_ready,
  input  logic          d_ready,
  output logic [AW:0]   a_count,
  output logic [AW:0]   b_count,
  output logic [AW:0]   c_count,
  output logic [AW:0]   d_count
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [15:0] mem_q    [4][DEPTH];
  logic [15:0] mem_d    [4][DEPTH];
  logic [AW-1:0] wr_ptr_q [4];
  logic [AW-1:0] wr_ptr_d [4];
  logic [AW-1:0] rd_ptr_q [4];
  logic [AW-1:0] rd_ptr_d [4];
  logic [AW:0]   count_q  [4];
  logic [AW:0]   count_d  [4];

  logic [3:0]  ch_valid;
  logic [3:0]  ch_full;
  logic [3:0]  ch_ready;
  logic [3:0]  push;
  logic [3:0]  pop;
  logic [15:0] head     [4];
  logic [15:0] data_out [4];

  assign ch_ready = {d_ready, c_ready, b_ready, a_ready};

  // Full/empty come from the occupancy count only; the pointers are equal
  // both when empty and when full, so they cannot tell the two apart.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_valid[i] = (count_q[i] != '0);
      ch_full[i]  = (count_q[i] == DEPTH_CNT);
    end
  end

  // A full channel refuses the word even if its consumer pops this same
  // cycle: the freed slot is only offered on the following cycle.
  assign in_ready = ~ch_full[sel];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      push[i] = in_valid && in_ready && (sel == 2'(i));
      pop[i]  = ch_valid[i] && ch_ready[i];
    end
  end

  // Next-state for all four FIFOs. Pointers are AW bits wide, so the
  // increment wraps modulo DEPTH on its own.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in;
        wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
      end
      unique case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + 1'b1;
        2'b01:   count_d[i] = count_q[i] - 1'b1;
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // Storage is cleared on reset so idle outputs read zero until written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          mem_q[i][j] <= '0;
        end
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head word selection, optionally masked to zero while the channel is empty.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      head[i] = mem_q[i][rd_ptr_q[i]];
`ifdef DMUX_ZERO_IDLE_EN
      data_out[i] = ch_valid[i] ? head[i] : 16'h0000;
`else
      data_out[i] = head[i];
`endif
    end
  end

  assign a = data_out[0];
  assign b = data_out[1];
  assign c = data_out[2];
  assign d = data_out[3];

  assign a_valid = ch_valid[0];
  assign b_valid = ch_valid[1];
  assign c_valid = ch_valid[2];
  assign d_valid = ch_valid[3];

  assign a_count = count_q[0];
  assign b_count = count_q[1];
  assign c_count = count_q[2];
  assign d_count = count_q[3];

endmodule

// File: tb/tb_student_dmux4way16_router.sv
// Directed bench for student_dmux4way16_router (DEPTH=2).
// Inputs change on the falling edge; outputs are checked on the falling edge
// (or #1 after an input change for the combinational in_ready).

module tb_student_dmux4way16_router;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b, c, d;
  logic        a_valid, b_valid, c_valid, d_valid;
  logic        a_ready, b_ready, c_ready, d_ready;
  logic [1:0]  a_count, b_count, c_count, d_count;

  int compared;
  int mismatched;

  student_dmux4way16_router #(.DEPTH(2), .AW(1)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .a_count(a_count), .b_count(b_count), .c_count(c_count), .d_count(d_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the producer side and all four consumer readies in one step.
  task automatic applyStimulus(input logic [15:0] word, input logic [1:0] s,
                               input logic v, input logic [3:0] rdy);
    in       = word;
    sel      = s;
    in_valid = v;
    {d_ready, c_ready, b_ready, a_ready} = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] idle_exp;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    applyStimulus(16'h0000, 2'b00, 1'b0, 4'b0000);
    #2;
    checkOutput("por_a_valid", a_valid, 1'b0);
    checkOutput("por_d_count", d_count, 2'd0);
    checkOutput("por_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Routing: one word per channel, consumers stalled.
    applyStimulus(16'h1234, 2'b00, 1'b1, 4'b0000);
    tick();
    checkOutput("route_a_valid", a_valid, 1'b1);
    checkOutput("route_a", a, 16'h1234);
    checkOutput("route_a_count", a_count, 2'd1);
    checkOutput("route_b_valid_idle", b_valid, 1'b0);
    applyStimulus(16'h9876, 2'b01, 1'b1, 4'b0000);
    tick();
    checkOutput("route_b", b, 16'h9876);
    checkOutput("route_b_count", b_count, 2'd1);
    checkOutput("route_a_kept", a, 16'h1234);
    checkOutput("route_c_valid_idle", c_valid, 1'b0);
    applyStimulus(16'hAAAA, 2'b10, 1'b1, 4'b0000);
    tick();
    checkOutput("route_c", c, 16'hAAAA);
    checkOutput("route_c_count", c_count, 2'd1);
    checkOutput("route_d_valid_idle", d_valid, 1'b0);
    applyStimulus(16'h5555, 2'b11, 1'b1, 4'b0000);
    tick();
    checkOutput("route_d", d, 16'h5555);
    checkOutput("route_d_valid", d_valid, 1'b1);
    applyStimulus(16'h0000, 2'b00, 1'b0, 4'b0000);
    tick();
    checkOutput("route_a_count_all", a_count, 2'd1);
    checkOutput("route_b_count_all", b_count, 2'd1);
    checkOutput("route_c_count_all", c_count, 2'd1);
    checkOutput("route_d_count_all", d_count, 2'd1);

    // Mid-run reset: all channels hold data; reset must clear with no edge.
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_a_valid", a_valid, 1'b0);
    checkOutput("rst_b_valid", b_valid, 1'b0);
    checkOutput("rst_c_valid", c_valid, 1'b0);
    checkOutput("rst_d_valid", d_valid, 1'b0);
    checkOutput("rst_counts", {a_count, b_count, c_count, d_count}, 8'h00);
    checkOutput("rst_ab", {a, b}, 32'h0);
    checkOutput("rst_cd", {c, d}, 32'h0);
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checkOutput("rst_in_ready", in_ready, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full / back-pressure on channel d.
    applyStimulus(16'h0001, 2'b11, 1'b1, 4'b0000);
    tick();
    applyStimulus(16'h0002, 2'b11, 1'b1, 4'b0000);
    tick();
    checkOutput("full_d_count", d_count, 2'd2);
    applyStimulus(16'h0003, 2'b11, 1'b1, 4'b0000);
    #1;
    checkOutput("full_in_ready_d", in_ready, 1'b0);
    sel = 2'b00;
    #1;
    checkOutput("full_in_ready_a", in_ready, 1'b1);
    applyStimulus(16'h0003, 2'b11, 1'b1, 4'b1000);
    #1;
    checkOutput("full_no_passthru", in_ready, 1'b0);
    tick();
    checkOutput("full_after_pop_count", d_count, 2'd1);
    checkOutput("full_after_pop_head", d, 16'h0002);
    checkOutput("full_a_untouched", a_count, 2'd0);
    applyStimulus(16'h0003, 2'b11, 1'b1, 4'b0000);
    #1;
    checkOutput("full_in_ready_freed", in_ready, 1'b1);
    tick();
    checkOutput("full_third_accepted", d_count, 2'd2);
    checkOutput("full_head_still_2", d, 16'h0002);
    applyStimulus(16'h0000, 2'b00, 1'b0, 4'b1000);
    tick();
    checkOutput("full_pop_third", d, 16'h0003);
    checkOutput("full_pop_count", d_count, 2'd1);
    tick();
    checkOutput("full_drained_valid", d_valid, 1'b0);
    checkOutput("full_drained_count", d_count, 2'd0);

    // Simultaneous push and pop on channel b.
    applyStimulus(16'h00B1, 2'b01, 1'b1, 4'b0000);
    tick();
    checkOutput("pp_b_first", b, 16'h00B1);
    applyStimulus(16'h00B2, 2'b01, 1'b1, 4'b0010);
    tick();
    checkOutput("pp_b_count", b_count, 2'd1);
    checkOutput("pp_b_head", b, 16'h00B2);
    applyStimulus(16'h0000, 2'b00, 1'b0, 4'b0010);
    tick();
    checkOutput("pp_b_empty", b_count, 2'd0);
    tick();
    checkOutput("pp_b_no_underflow", b_count, 2'd0);
    checkOutput("pp_b_valid_low", b_valid, 1'b0);

    // Wrap-around: streaming through channel c with the consumer always ready.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(16'(k), 2'b10, 1'b1, 4'b0100);
      tick();
      checkOutput("wrap_c_data", c, 32'(k));
      checkOutput("wrap_c_count", c_count, 2'd1);
    end
    applyStimulus(16'h0000, 2'b00, 1'b0, 4'b0100);
    tick();
    checkOutput("wrap_c_drained", c_count, 2'd0);

    // Idle data on channel a: fill both slots, drain, read pointer back at 0.
    applyStimulus(16'hA5A5, 2'b00, 1'b1, 4'b0000);
    tick();
    applyStimulus(16'h5A5A, 2'b00, 1'b1, 4'b0000);
    tick();
    applyStimulus(16'h0000, 2'b00, 1'b0, 4'b0001);
    tick();
    checkOutput("idle_a_second", a, 16'h5A5A);
    tick();
    checkOutput("idle_a_valid", a_valid, 1'b0);
`ifdef DMUX_ZERO_IDLE_EN
    idle_exp = 16'h0000;
`else
    idle_exp = 16'hA5A5;
`endif
    checkOutput("idle_a_data", a, idle_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
